sp_ram_ctrl: RTL

//  Initiator for the single-port RAM (sp_ram): accepts read/write requests on a

---
 rtl/sp_ram_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sp_ram_ctrl.sv
// Valid/ready initiator for a single-port RAM: write/read bursts over consecutive
// addresses, read data returned on a response port. Optional RAM_CLEAR_EN zero-fills the RAM after reset.
module sp_ram_ctrl #(
   parameter int AW = 4,
   parameter int DW = 8,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   input  logic [LW-1:0] req_len,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic          busy,
   output logic          chip_enable,
   output logic          write_enable,
   output logic [DW-1:0] din,
   output logic [AW-1:0] address,
   input  logic [DW-1:0] dout
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP, S_INIT} state_t;

`ifdef RAM_CLEAR_EN
   localparam state_t RST_STATE = S_INIT;
   localparam logic   RST_READY = 1'b0;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_t RST_STATE = S_IDLE;
   localparam logic   RST_READY = 1'b1;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d, busy_q, busy_d;
   logic          rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d, din_q, din_d;
   logic          ce_q, ce_d, we_q, we_d;
   logic [AW-1:0] address_q, address_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RST_STATE;
         addr_q      <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         req_ready_q <= RST_READY;
         busy_q      <= RST_BUSY;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         ce_q        <= 1'b0;
         we_q        <= 1'b0;
         din_q       <= '0;
         address_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
         ce_q        <= ce_d;
         we_q        <= we_d;
         din_q       <= din_d;
         address_q   <= address_d;
      end
   end

   // cnt_q holds the number of beats still to go after the current one
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (req_valid && req_ready_q) begin
            addr_d  = req_addr;
            data_d  = req_data;
            cnt_d   = req_len;
            state_d = req_write ? S_WRITE : S_READ;
         end
         S_WRITE: if (cnt_q == '0) state_d = S_IDLE;
            else begin
               cnt_d  = cnt_q - LW'(1);
               addr_d = addr_q + AW'(1);
            end
         S_READ: state_d = S_WAIT;
         S_WAIT: state_d = S_RESP;
         S_RESP: if (rsp_ready) begin
            if (cnt_q == '0) state_d = S_IDLE;
            else begin
               cnt_d   = cnt_q - LW'(1);
               addr_d  = addr_q + AW'(1);
               state_d = S_READ;
            end
         end
`ifdef RAM_CLEAR_EN
         S_INIT: if (ce_q && (&address_q)) state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with it
   always_comb begin
      ce_d        = (state_d == S_WRITE) || (state_d == S_READ);
      we_d        = (state_d == S_WRITE);
      address_d   = addr_d;
      din_d       = data_d;
      rsp_valid_d = (state_d == S_RESP);
      rsp_last_d  = (state_d == S_RESP) && (cnt_d == '0);
      rsp_data_d  = (state_q == S_WAIT) ? dout : rsp_data_q;
      busy_d      = (state_d != S_IDLE);
      req_ready_d = (state_d == S_IDLE);
`ifdef RAM_CLEAR_EN
      if (state_d == S_INIT) begin
         ce_d      = 1'b1;
         we_d      = 1'b1;
         din_d     = '0;
         address_d = ce_q ? address_q + AW'(1) : '0;
      end
`endif
   end

   assign req_ready    = req_ready_q;
   assign busy         = busy_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_last     = rsp_last_q;
   assign rsp_data     = rsp_data_q;
   assign chip_enable  = ce_q;
   assign write_enable = we_q;
   assign din          = din_q;
   assign address      = address_q;

endmodule
